// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: opcodes, functs, CP0 indices and exception codes.
// Subword load/store opcodes are decoded only when SUBWORD_MEM_EN is defined.
package mips_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
    localparam logic [31:0] INT_ACK_ADDR = 32'h0000_7F20;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ERET    = 6'h18;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [4:0] C0_MF = 5'h00;
    localparam logic [4:0] C0_MT = 5'h04;
    localparam logic [4:0] C0_CO = 5'h10;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;

    // Only IM[15:10], EXL and IE exist in SR; everything else reads back as zero.
    localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_JUMP,
        NPC_JR,
        NPC_ERET
    } npc_sel_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_sc_core_if.sv
// Memory, interrupt and commit-trace bus of the MIPS core as seen by its system environment.
// master = core side, slave = memories / interrupt generator / trace consumer.
interface mips_sc_core_if;

    logic        interrupt;
    logic [31:0] macroscopic_pc;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_rdata;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic [31:0] m_inst_addr;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    modport master (
        input  interrupt, i_inst_rdata, m_data_rdata,
        output macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
               m_int_addr, m_int_byteen, m_inst_addr, w_grf_we, w_grf_addr,
               w_grf_wdata, w_inst_addr
    );

    modport slave (
        output interrupt, i_inst_rdata, m_data_rdata,
        input  macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
               m_int_addr, m_int_byteen, m_inst_addr, w_grf_we, w_grf_addr,
               w_grf_wdata, w_inst_addr
    );

endinterface

// File: rtl/mips_cp0.sv
// Coprocessor 0: SR/Cause/EPC, interrupt qualification, exception entry and eret.
module mips_cp0
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt_i,
    input  logic [31:0] pc_i,
    input  logic        mtc0_i,
    input  logic        eret_i,
    input  logic        exc_ri_i,
    input  logic        exc_sys_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] epc_o,
    output logic        exc_taken_o
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        irq;

    assign irq         = interrupt_i & sr_q[12] & sr_q[0] & ~sr_q[1];
    assign exc_taken_o = irq | exc_ri_i | exc_sys_i;
    assign epc_o       = epc_q;

    // An exception suppresses the instruction's own CP0 side effects (mtc0, eret).
    always_comb begin
        sr_d       = sr_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        if (exc_taken_o) begin
            epc_d      = pc_i;
            exc_code_d = irq ? EXC_INT : (exc_ri_i ? EXC_RI : EXC_SYS);
            sr_d[1]    = 1'b1;
        end else if (eret_i) begin
            sr_d[1] = 1'b0;
        end else if (mtc0_i) begin
            case (addr_i)
                CP0_SR:  sr_d  = wdata_i & SR_WMASK;
                CP0_EPC: epc_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_SR:    rdata_o = sr_q;
            CP0_CAUSE: rdata_o = {16'b0, 3'b0, interrupt_i, 5'b0, exc_code_q, 2'b0};
            CP0_EPC:   rdata_o = epc_q;
            default:   rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            epc_q      <= '0;
            exc_code_q <= '0;
        end else begin
            sr_q       <= sr_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
        end
    end

endmodule

// File: rtl/mips_sc_core.sv
// Single-cycle MIPS-I subset core: PC, GRF, decode/ALU, store routing to memory or interrupt ack.
// Define SUBWORD_MEM_EN to add lb/lbu/lh/lhu/sb/sh; otherwise those opcodes raise RI.
module mips_sc_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] grf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_s, pc_plus4, load_word;
    logic        in_ack;

    logic        wr_en, exc_ri, exc_sys, mtc0, eret;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, store_data;
    logic [3:0]  store_be;
    npc_sel_e    npc_sel;

    logic [31:0] cp0_rdata, epc;
    logic        exc_taken;

    assign op    = i_inst_rdata[31:26];
    assign rs    = i_inst_rdata[25:21];
    assign rt    = i_inst_rdata[20:16];
    assign rd    = i_inst_rdata[15:11];
    assign shamt = i_inst_rdata[10:6];
    assign funct = i_inst_rdata[5:0];
    assign imm   = i_inst_rdata[15:0];

    assign rs_val    = (rs == 5'd0) ? '0 : grf_q[rs];
    assign rt_val    = (rt == 5'd0) ? '0 : grf_q[rt];
    assign imm_s     = sext16(imm);
    assign pc_plus4  = pc_q + 32'd4;
    assign in_ack    = (m_data_addr[31:2] == INT_ACK_ADDR[31:2]);
    assign load_word = in_ack ? '0 : m_data_rdata;

`ifdef SUBWORD_MEM_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign ld_byte = load_word[{m_data_addr[1:0], 3'b000} +: 8];
    assign ld_half = load_word[{m_data_addr[1], 4'b0000} +: 16];
`endif

    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = rt;
        wr_data    = '0;
        store_be   = 4'b0000;
        store_data = rt_val;
        npc_sel    = NPC_SEQ;
        exc_ri     = 1'b0;
        exc_sys    = 1'b0;
        mtc0       = 1'b0;
        eret       = 1'b0;
        case (op)
            OP_SPECIAL: begin
                wr_addr = rd;
                case (funct)
                    FN_ADDU:    begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
                    FN_SUBU:    begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
                    FN_AND:     begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
                    FN_OR:      begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
                    FN_SLT:     begin wr_en = 1'b1; wr_data = {31'b0, $signed(rs_val) < $signed(rt_val)}; end
                    FN_SLTU:    begin wr_en = 1'b1; wr_data = {31'b0, rs_val < rt_val}; end
                    FN_SLL:     begin wr_en = 1'b1; wr_data = rt_val << shamt; end
                    FN_JR:      npc_sel = NPC_JR;
                    FN_SYSCALL: exc_sys = 1'b1;
                    default:    exc_ri = 1'b1;
                endcase
            end
            OP_J:     npc_sel = NPC_JUMP;
            OP_JAL:   begin npc_sel = NPC_JUMP; wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_plus4; end
            OP_BEQ:   if (rs_val == rt_val) npc_sel = NPC_BRANCH;
            OP_BNE:   if (rs_val != rt_val) npc_sel = NPC_BRANCH;
            OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + imm_s; end
            OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & {16'b0, imm}; end
            OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | {16'b0, imm}; end
            OP_LUI:   begin wr_en = 1'b1; wr_data = {imm, 16'b0}; end
            OP_LW:    begin wr_en = 1'b1; wr_data = load_word; end
            OP_SW:    store_be = 4'b1111;
`ifdef SUBWORD_MEM_EN
            OP_LB:    begin wr_en = 1'b1; wr_data = {{24{ld_byte[7]}}, ld_byte}; end
            OP_LBU:   begin wr_en = 1'b1; wr_data = {24'b0, ld_byte}; end
            OP_LH:    begin wr_en = 1'b1; wr_data = {{16{ld_half[15]}}, ld_half}; end
            OP_LHU:   begin wr_en = 1'b1; wr_data = {16'b0, ld_half}; end
            OP_SB:    begin store_be = 4'b0001 << m_data_addr[1:0]; store_data = {4{rt_val[7:0]}}; end
            OP_SH:    begin store_be = 4'b0011 << {m_data_addr[1], 1'b0}; store_data = {2{rt_val[15:0]}}; end
`else
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: exc_ri = 1'b1;
`endif
            OP_COP0: begin
                case (rs)
                    C0_MF:   begin wr_en = 1'b1; wr_data = cp0_rdata; end
                    C0_MT:   mtc0 = 1'b1;
                    C0_CO:   if (funct == FN_ERET) begin eret = 1'b1; npc_sel = NPC_ERET; end
                             else exc_ri = 1'b1;
                    default: exc_ri = 1'b1;
                endcase
            end
            default: exc_ri = 1'b1;
        endcase
    end

    mips_cp0 u_cp0 (
        .clk         (clk),
        .rst         (reset),
        .interrupt_i (interrupt),
        .pc_i        (pc_q),
        .mtc0_i      (mtc0),
        .eret_i      (eret),
        .exc_ri_i    (exc_ri),
        .exc_sys_i   (exc_sys),
        .addr_i      (rd),
        .wdata_i     (rt_val),
        .rdata_o     (cp0_rdata),
        .epc_o       (epc),
        .exc_taken_o (exc_taken)
    );

    always_comb begin
        pc_d = pc_plus4;
        if (exc_taken) begin
            pc_d = HANDLER_PC;
        end else begin
            case (npc_sel)
                NPC_BRANCH: pc_d = pc_plus4 + {imm_s[29:0], 2'b00};
                NPC_JUMP:   pc_d = {pc_q[31:28], i_inst_rdata[25:0], 2'b00};
                NPC_JR:     pc_d = rs_val;
                NPC_ERET:   pc_d = epc;
                default:    pc_d = pc_plus4;
            endcase
        end
    end

    assign macroscopic_pc = pc_q;
    assign i_inst_addr    = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;
    assign m_data_addr    = rs_val + imm_s;
    assign m_int_addr     = m_data_addr;
    assign m_data_wdata   = store_data;
    assign m_data_byteen  = (exc_taken || in_ack) ? 4'b0000 : store_be;
    assign m_int_byteen   = (!exc_taken && in_ack) ? store_be : 4'b0000;
    assign w_grf_we       = wr_en & ~exc_taken;
    assign w_grf_addr     = wr_addr;
    assign w_grf_wdata    = wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // $0 writes are visible on the trace port but never land in the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= '0;
        end else if (w_grf_we && (w_grf_addr != 5'd0)) begin
            grf_q[w_grf_addr] <= w_grf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_sc_core.sv
// Directed program test of mips_sc_core with combinational instruction/data memories in the bench.
module tb_mips_sc_core;

   logic clk;
   logic reset;
   int   passCount;
   int   checkCount;

   logic [31:0] imem [2048];
   logic [31:0] dmem [256];

   mips_sc_core_if bus ();

   mips_sc_core dut (
      .clk            (clk),
      .reset          (reset),
      .interrupt      (bus.interrupt),
      .macroscopic_pc (bus.macroscopic_pc),
      .i_inst_addr    (bus.i_inst_addr),
      .i_inst_rdata   (bus.i_inst_rdata),
      .m_data_addr    (bus.m_data_addr),
      .m_data_rdata   (bus.m_data_rdata),
      .m_data_wdata   (bus.m_data_wdata),
      .m_data_byteen  (bus.m_data_byteen),
      .m_int_addr     (bus.m_int_addr),
      .m_int_byteen   (bus.m_int_byteen),
      .m_inst_addr    (bus.m_inst_addr),
      .w_grf_we       (bus.w_grf_we),
      .w_grf_addr     (bus.w_grf_addr),
      .w_grf_wdata    (bus.w_grf_wdata),
      .w_inst_addr    (bus.w_inst_addr)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational memories indexed by word address.
   assign bus.i_inst_rdata = imem[bus.i_inst_addr[12:2]];
   assign bus.m_data_rdata = dmem[bus.m_data_addr[9:2]];

   // Data memory takes byte-enabled stores on the rising edge.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (bus.m_data_byteen[b]) dmem[bus.m_data_addr[9:2]][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
   end

   task automatic loadWord(input logic [31:0] addr, input logic [31:0] word);
      imem[addr[12:2]] = word;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   initial begin
      passCount     = 0;
      checkCount    = 0;
      reset         = 1'b1;
      bus.interrupt = 1'b0;
      for (int i = 0; i < 2048; i++) imem[i] = 32'h0000_0000;

      loadWord(32'h3000, 32'h3401_1234);   // ori   $1,$0,0x1234
      loadWord(32'h3004, 32'h3C02_FFFF);   // lui   $2,0xFFFF
      loadWord(32'h3008, 32'h2443_FFFF);   // addiu $3,$2,-1
      loadWord(32'h300C, 32'hAC03_0008);   // sw    $3,8($0)
      loadWord(32'h3010, 32'h3405_1001);   // ori   $5,$0,0x1001
      loadWord(32'h3014, 32'h4085_6000);   // mtc0  $5,$12
      loadWord(32'h3018, 32'h8C04_0008);   // lw    $4,8($0)
      loadWord(32'h301C, 32'h4009_6000);   // mfc0  $9,$12
      loadWord(32'h3020, 32'h0023_3021);   // addu  $6,$1,$3
      loadWord(32'h3024, 32'h0023_5023);   // subu  $10,$1,$3
      loadWord(32'h3028, 32'h0061_582A);   // slt   $11,$3,$1
      loadWord(32'h302C, 32'h0061_602B);   // sltu  $12,$3,$1
      loadWord(32'h3030, 32'h0001_6900);   // sll   $13,$1,4
      loadWord(32'h3034, 32'h0023_7024);   // and   $14,$1,$3
      loadWord(32'h3038, 32'h0041_7825);   // or    $15,$2,$1
      loadWord(32'h303C, 32'h3400_0005);   // ori   $0,$0,5
      loadWord(32'h3040, 32'h0000_8021);   // addu  $16,$0,$0
      loadWord(32'h3044, 32'h0C00_0C18);   // jal   0x3060
      loadWord(32'h3048, 32'hFC00_0000);   // reserved opcode 0x3F
      loadWord(32'h3060, 32'h1021_0002);   // beq   $1,$1,+2
      loadWord(32'h3064, 32'h3414_0001);   // ori   $20,$0,1 (skipped)
      loadWord(32'h3068, 32'h3414_0002);   // ori   $20,$0,2 (skipped)
      loadWord(32'h306C, 32'h1421_0004);   // bne   $1,$1,+4
      loadWord(32'h3070, 32'h3071_FFFF);   // andi  $17,$3,0xFFFF
      loadWord(32'h3074, 32'hAC00_7F24);   // sw    $0,0x7F24($0)
      loadWord(32'h3078, 32'h03E0_0008);   // jr    $31
      loadWord(32'h4180, 32'h4007_6800);   // mfc0  $7,$13
      loadWord(32'h4184, 32'h4008_7000);   // mfc0  $8,$14
      loadWord(32'h4188, 32'hAC00_7F20);   // sw    $0,0x7F20($0)
      loadWord(32'h418C, 32'h4200_0018);   // eret

      applyStimulus();
      checkOutput("reset_pc", bus.macroscopic_pc, 32'h3000);
      applyStimulus();
      reset = 1'b0;

      checkOutput("ori_we", {31'b0, bus.w_grf_we}, 32'd1);
      checkOutput("ori_addr", {27'b0, bus.w_grf_addr}, 32'd1);
      checkOutput("ori_wdata", bus.w_grf_wdata, 32'h0000_1234);
      checkOutput("ori_inst_addr", bus.w_inst_addr, 32'h3000);

      applyStimulus();
      checkOutput("lui_wdata", bus.w_grf_wdata, 32'hFFFF_0000);
      applyStimulus();
      checkOutput("addiu_wdata", bus.w_grf_wdata, 32'hFFFE_FFFF);
      checkOutput("addiu_addr", {27'b0, bus.w_grf_addr}, 32'd3);
      applyStimulus();
      checkOutput("sw_byteen", {28'b0, bus.m_data_byteen}, 32'hF);
      checkOutput("sw_addr", bus.m_data_addr, 32'h8);
      checkOutput("sw_wdata", bus.m_data_wdata, 32'hFFFE_FFFF);
      checkOutput("sw_int_byteen", {28'b0, bus.m_int_byteen}, 32'h0);
      checkOutput("sw_we", {31'b0, bus.w_grf_we}, 32'd0);
      applyStimulus();
      checkOutput("pc_3010", bus.macroscopic_pc, 32'h3010);
      applyStimulus();
      checkOutput("mtc0_we", {31'b0, bus.w_grf_we}, 32'd0);

      // Interrupt arrives while lw at 0x3018 is executing; lw must not commit.
      applyStimulus();
      bus.interrupt = 1'b1;
      #1;
      checkOutput("irq_pc", bus.macroscopic_pc, 32'h3018);
      checkOutput("irq_we", {31'b0, bus.w_grf_we}, 32'd0);
      applyStimulus();
      checkOutput("irq_handler_pc", bus.macroscopic_pc, 32'h4180);
      checkOutput("irq_cause", bus.w_grf_wdata, 32'h0000_1000);
      checkOutput("irq_cause_addr", {27'b0, bus.w_grf_addr}, 32'd7);
      applyStimulus();
      checkOutput("irq_epc", bus.w_grf_wdata, 32'h3018);
      applyStimulus();
      checkOutput("ack_int_byteen", {28'b0, bus.m_int_byteen}, 32'hF);
      checkOutput("ack_data_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
      checkOutput("ack_int_addr", bus.m_int_addr, 32'h7F20);
      bus.interrupt = 1'b0;
      applyStimulus();
      checkOutput("eret_we", {31'b0, bus.w_grf_we}, 32'd0);
      applyStimulus();
      checkOutput("eret_pc", bus.macroscopic_pc, 32'h3018);
      checkOutput("lw_wdata", bus.w_grf_wdata, 32'hFFFE_FFFF);
      checkOutput("lw_addr", {27'b0, bus.w_grf_addr}, 32'd4);
      applyStimulus();
      checkOutput("sr_after_eret", bus.w_grf_wdata, 32'h0000_1001);

      applyStimulus();
      checkOutput("addu", bus.w_grf_wdata, 32'hFFFF_1233);
      applyStimulus();
      checkOutput("subu", bus.w_grf_wdata, 32'h0001_1235);
      applyStimulus();
      checkOutput("slt", bus.w_grf_wdata, 32'h1);
      applyStimulus();
      checkOutput("sltu", bus.w_grf_wdata, 32'h0);
      applyStimulus();
      checkOutput("sll", bus.w_grf_wdata, 32'h0001_2340);
      applyStimulus();
      checkOutput("and", bus.w_grf_wdata, 32'h0000_1234);
      applyStimulus();
      checkOutput("or", bus.w_grf_wdata, 32'hFFFF_1234);
      applyStimulus();
      applyStimulus();
      checkOutput("zero_reg", bus.w_grf_wdata, 32'h0);
      applyStimulus();
      checkOutput("jal_addr", {27'b0, bus.w_grf_addr}, 32'd31);
      checkOutput("jal_link", bus.w_grf_wdata, 32'h3048);
      applyStimulus();
      checkOutput("jal_target", bus.macroscopic_pc, 32'h3060);
      applyStimulus();
      checkOutput("beq_taken", bus.macroscopic_pc, 32'h306C);
      applyStimulus();
      checkOutput("bne_not_taken", bus.macroscopic_pc, 32'h3070);
      checkOutput("andi_zext", bus.w_grf_wdata, 32'h0000_FFFF);
      applyStimulus();
      checkOutput("past_ack_data_byteen", {28'b0, bus.m_data_byteen}, 32'hF);
      checkOutput("past_ack_int_byteen", {28'b0, bus.m_int_byteen}, 32'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("jr_target", bus.macroscopic_pc, 32'h3048);
      checkOutput("ri_we", {31'b0, bus.w_grf_we}, 32'd0);
      applyStimulus();
      checkOutput("ri_handler_pc", bus.macroscopic_pc, 32'h4180);
      checkOutput("ri_cause", bus.w_grf_wdata, 32'h0000_0028);
      applyStimulus();
      checkOutput("ri_epc", bus.w_grf_wdata, 32'h3048);

      // Reset mid-run, then check the GPRs were cleared and exercise syscall.
      reset = 1'b1;
      #1;
      checkOutput("midrun_reset_pc", bus.macroscopic_pc, 32'h3000);
      loadWord(32'h3000, 32'h003F_0821);  // addu $1,$1,$31
      loadWord(32'h3004, 32'h0000_000C);  // syscall
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("gpr_cleared", bus.w_grf_wdata, 32'h0);
      applyStimulus();
      checkOutput("syscall_we", {31'b0, bus.w_grf_we}, 32'd0);
      applyStimulus();
      checkOutput("syscall_handler_pc", bus.macroscopic_pc, 32'h4180);
      checkOutput("syscall_cause", bus.w_grf_wdata, 32'h0000_0020);
      applyStimulus();
      checkOutput("syscall_epc", bus.w_grf_wdata, 32'h3004);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
